// File: rtl/tdm_pkg.sv
// Shared types and sizes for the tdm_demux4 receive path.
// The err_cnt feature is enabled by defining TDM_DEMUX_ERRCNT_EN.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int TDM_SLOTS  = 4;
  localparam int TDM_SLOT_W = 2;
  localparam int ERRCNT_W   = 8;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter for the TDM demux.
// Provides clear, load-to-1 on sync accept, advance, and a last-slot flag.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  ld1,
  input  logic                  clr,
  output logic [TDM_SLOT_W-1:0] slot,
  output logic                  wrap
);

  localparam logic [TDM_SLOT_W-1:0] LAST =
    TDM_SLOT_W'(TDM_SLOTS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (ld1) begin
      slot <= TDM_SLOT_W'(1);
    end else if (en) begin
      slot <= slot + TDM_SLOT_W'(1);
    end
  end

  assign wrap = (slot == LAST);

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer with frame-sync lock and flywheel.
// Define TDM_DEMUX_ERRCNT_EN to add the saturating err_cnt output.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W         = 1,
  parameter int SYNC_LOSS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W-1:0]        d,
  input  logic                en,
  input  logic                fs,
`ifdef TDM_DEMUX_ERRCNT_EN
  output logic [ERRCNT_W-1:0] err_cnt,
`endif
  output logic [W-1:0]        o0,
  output logic [W-1:0]        o1,
  output logic [W-1:0]        o2,
  output logic [W-1:0]        o3,
  output logic                valid,
  output logic [1:0]          s,
  output logic                locked
);

  localparam logic [3:0] LOSS = 4'(SYNC_LOSS);

  state_t state, nstate;

  logic [TDM_SLOT_W-1:0] slot;
  logic                  wrap;
  logic                  zero;
  logic                  mid;
  logic [3:0]            miss;
  logic [W-1:0]          sh0, sh1, sh2;

  logic adv, ld1, clr;
  logic cap0, capn, done;
  logic miss_clr, miss_inc;

  tdm_slot_ctr u_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .ld1   (ld1),
    .clr   (clr),
    .slot  (slot),
    .wrap  (wrap)
  );

  assign zero = (slot == '0);
  assign mid  = !zero && !wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate   = state;
    adv      = 1'b0;
    ld1      = 1'b0;
    clr      = 1'b0;
    cap0     = 1'b0;
    capn     = 1'b0;
    done     = 1'b0;
    miss_clr = 1'b0;
    miss_inc = 1'b0;
    if (en) begin
      unique case (state)
        HUNT: begin
          if (fs) begin
            nstate   = LOCK;
            ld1      = 1'b1;
            cap0     = 1'b1;
            miss_clr = 1'b1;
          end
        end
        LOCK: begin
          // fs always restarts at slot 0, early or on time
          unique case (1'b1)
            fs: begin
              ld1      = 1'b1;
              cap0     = 1'b1;
              miss_clr = 1'b1;
            end
            (!fs && zero): begin
              if (miss + 4'd1 == LOSS) begin
                nstate   = HUNT;
                clr      = 1'b1;
                miss_clr = 1'b1;
              end else begin
                cap0     = 1'b1;
                adv      = 1'b1;
                miss_inc = 1'b1;
              end
            end
            (!fs && wrap): begin
              done = 1'b1;
              adv  = 1'b1;
            end
            (!fs && mid): begin
              capn = 1'b1;
              adv  = 1'b1;
            end
            default: ;
          endcase
        end
        default: nstate = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh0   <= '0;
      sh1   <= '0;
      sh2   <= '0;
      o0    <= '0;
      o1    <= '0;
      o2    <= '0;
      o3    <= '0;
      valid <= 1'b0;
      miss  <= '0;
    end else begin
      valid <= done;
      if (cap0) sh0 <= d;
      if (capn && slot == 2'd1) sh1 <= d;
      if (capn && slot == 2'd2) sh2 <= d;
      // slot 3 bypasses the shadows so the frame lands in one edge
      if (done) begin
        o0 <= sh0;
        o1 <= sh1;
        o2 <= sh2;
        o3 <= d;
      end
      if (miss_clr) begin
        miss <= '0;
      end else if (miss_inc) begin
        miss <= miss + 4'd1;
      end
    end
  end

  assign s      = slot;
  assign locked = (state == LOCK);

`ifdef TDM_DEMUX_ERRCNT_EN
  logic err_ev;

  assign err_ev = en && (state == LOCK) &&
                  ((fs && !zero) || (!fs && zero));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_ev && err_cnt != '1) begin
      err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end
`else
  // no error counter in this build
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed and random bench for tdm_demux4 against a frame-level model.
// Checks err_cnt only when TDM_DEMUX_ERRCNT_EN is defined.
module tb_tdm_demux4;

  localparam int W  = 4;
  localparam int SL = 3;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         en    = 1'b0;
  logic         fs    = 1'b0;
  logic [W-1:0] d     = '0;
  logic [W-1:0] o0, o1, o2, o3;
  logic         valid;
  logic [1:0]   s;
  logic         locked;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0]   err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // frame-level reference state
  bit           m_lock;
  int           m_slot;
  int           m_miss;
  int           m_err;
  bit           m_valid;
  logic [W-1:0] m_buf [4];
  logic [W-1:0] m_out [4];

  tdm_demux4 #(.W(W), .SYNC_LOSS(SL)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (d),
    .en     (en),
    .fs     (fs),
`ifdef TDM_DEMUX_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .o0     (o0),
    .o1     (o1),
    .o2     (o2),
    .o3     (o3),
    .valid  (valid),
    .s      (s),
    .locked (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_lock  = 0;
    m_slot  = 0;
    m_miss  = 0;
    m_err   = 0;
    m_valid = 0;
    for (int i = 0; i < 4; i++) begin
      m_buf[i] = '0;
      m_out[i] = '0;
    end
  endfunction

  function automatic void bump_err();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void model_step(bit e, bit f, logic [W-1:0] x);
    m_valid = 0;
    if (!e) return;
    if (!m_lock) begin
      if (f) begin
        m_lock   = 1;
        m_buf[0] = x;
        m_slot   = 1;
        m_miss   = 0;
      end
    end else if (f) begin
      if (m_slot != 0) bump_err();
      m_buf[0] = x;
      m_slot   = 1;
      m_miss   = 0;
    end else if (m_slot == 0) begin
      bump_err();
      m_miss++;
      if (m_miss >= SL) begin
        m_lock = 0;
        m_miss = 0;
      end else begin
        m_buf[0] = x;
        m_slot   = 1;
      end
    end else if (m_slot == 3) begin
      m_out[0] = m_buf[0];
      m_out[1] = m_buf[1];
      m_out[2] = m_buf[2];
      m_out[3] = x;
      m_valid  = 1;
      m_slot   = 0;
    end else begin
      m_buf[m_slot] = x;
      m_slot++;
    end
  endfunction

  task automatic check_all(string tag);
    chk({tag, ".o0"}, 32'(o0), 32'(m_out[0]));
    chk({tag, ".o1"}, 32'(o1), 32'(m_out[1]));
    chk({tag, ".o2"}, 32'(o2), 32'(m_out[2]));
    chk({tag, ".o3"}, 32'(o3), 32'(m_out[3]));
    chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
    chk({tag, ".s"}, 32'(s), 32'(m_slot));
    chk({tag, ".locked"}, 32'(locked), 32'(m_lock));
`ifdef TDM_DEMUX_ERRCNT_EN
    chk({tag, ".err"}, 32'(err_cnt), 32'(m_err));
`endif
  endtask

  task automatic step(bit e, bit f, logic [W-1:0] x, string tag);
    @(negedge clk);
    en = e;
    fs = f;
    d  = x;
    @(posedge clk);
    model_step(e, f, x);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    check_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    step(1, 1, 4'hA, "clean0");
    step(1, 0, 4'h5, "clean1");
    step(1, 0, 4'h3, "clean2");
    step(1, 0, 4'hC, "clean3");
    chk("clean_o", {o0, o1, o2, o3}, 32'hA53C);
    chk("clean_valid", 32'(valid), 32'd1);
    chk("clean_locked", 32'(locked), 32'd1);
    step(1, 1, 4'h1, "clean_next");
    chk("clean_pulse", 32'(valid), 32'd0);

    do_reset("rst_a");
    step(1, 1, 4'hA, "gap0");
    step(1, 0, 4'h5, "gap1");
    step(0, 0, 4'hF, "gap_idle0");
    chk("gap_s_hold", 32'(s), 32'd2);
    step(0, 1, 4'hE, "gap_idle1");
    chk("gap_s_hold2", 32'(s), 32'd2);
    step(1, 0, 4'h3, "gap2");
    step(1, 0, 4'hC, "gap3");
    chk("gap_o", {o0, o1, o2, o3}, 32'hA53C);
    chk("gap_valid", 32'(valid), 32'd1);

    for (int fr = 0; fr < 2; fr++) begin
      for (int k = 0; k < 4; k++)
        step(1, 0, 4'(fr * 4 + k + 1), "fly");
      chk("fly_valid", 32'(valid), 32'd1);
      chk("fly_locked", 32'(locked), 32'd1);
    end
    chk("fly_o", {o0, o1, o2, o3}, 32'h5678);
`ifdef TDM_DEMUX_ERRCNT_EN
    chk("fly_err", 32'(err_cnt), 32'd2);
`endif
    step(1, 0, 4'h9, "loss");
    chk("loss_locked", 32'(locked), 32'd0);
    for (int k = 0; k < 8; k++)
      step(1, 0, 4'(k), "hunt");

    step(1, 1, 4'h1, "early0");
    step(1, 0, 4'h2, "early1");
    chk("early_s2", 32'(s), 32'd2);
    step(1, 1, 4'h7, "early_fs");
    chk("early_s1", 32'(s), 32'd1);
    chk("early_o", {o0, o1, o2, o3}, 32'h5678);
    step(1, 0, 4'h8, "early_c1");
    step(1, 0, 4'h9, "early_c2");
    step(1, 0, 4'hB, "early_c3");
    chk("early_frame", {o0, o1, o2, o3}, 32'h789B);
    chk("early_valid", 32'(valid), 32'd1);

    step(1, 1, 4'h4, "mid0");
    step(1, 0, 4'h5, "mid1");
    step(1, 0, 4'h6, "mid2");
    do_reset("rst_mid");
    chk("rst_mid_s", 32'(s), 32'd0);
    step(1, 1, 4'hD, "rel_fs");
    chk("rel_locked", 32'(locked), 32'd1);

`ifdef TDM_DEMUX_ERRCNT_EN
    for (int k = 0; k < 301; k++)
      step(1, 1, 4'(k), "sat");
    chk("sat_err", 32'(err_cnt), 32'd255);
    step(1, 1, 4'h0, "sat_hold");
    chk("sat_hold_err", 32'(err_cnt), 32'd255);
`endif

    for (int k = 0; k < 600; k++) begin
      bit e, f;
      e = ($urandom_range(0, 3) != 0);
      if (!m_lock)
        f = ($urandom_range(0, 3) == 0);
      else if (m_slot == 0)
        f = ($urandom_range(0, 7) != 0);
      else
        f = ($urandom_range(0, 15) == 0);
      step(e, f, W'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive end of a 4:1 mux link. One sample of width W arrives per enabled clock, and a frame-sync flag marks slot 0. The block locks to frame sync, steers each slot into a shadow register, and presents all four channels as registered outputs with a one-cycle `valid` pulse per completed frame. It sits at the far end of a serial/TDM path and feeds per-channel consumers.

## Interface
- `W`, default 1: sample width in bits.
- `SYNC_LOSS`, default 3: number of consecutive missing frame syncs that forces loss of lock (range 1–15).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `d` input W: serial sample for the current slot.
- `en` input 1: sample strobe; `d` and `fs` are ignored when low.
- `fs` input 1: frame sync, asserted with the slot-0 sample.
- `o0`, `o1`, `o2`, `o3` output W each: registered channel outputs.
- `valid` output 1: one-cycle pulse when `o0`..`o3` update.
- `s` output 2: slot index the next enabled sample will fill; `s[1]` = s1, `s[0]` = s0.
- `locked` output 1: high in state LOCK.
- `err_cnt` output 8: sync error count; present only with `TDM_DEMUX_ERRCNT_EN`.

## Operation
- Reset values: `o0`..`o3` = 0, `valid` = 0, `s` = 0, `locked` = 0, `err_cnt` = 0, state = HUNT, miss counter = 0, shadow registers = 0.
- States: HUNT and LOCK.
- **HUNT:**
  - Enabled samples with `fs` = 0 are discarded.
  - `en` & `fs`: capture `d` into shadow 0, set `s` = 1, go to LOCK, clear the miss counter.
- **LOCK, `en` = 1, `s` = 1..3, `fs` = 0:** capture `d` into shadow[`s`], then `s` increments.
- **LOCK, `s` = 3:**
  - On the same edge, `o0`..`o2` load from shadow 0..2 and `o3` loads `d` directly.
  - `valid` = 1 for that one cycle.
  - `s` wraps to 0.
- **LOCK, `s` = 0, `fs` = 1:** capture into shadow 0, clear the miss counter, `s` = 1.
- **LOCK, `s` = 0, `fs` = 0 (flywheel):**
  - Capture into shadow 0 anyway and increment the miss counter; `err_cnt` += 1.
  - If the miss counter reaches `SYNC_LOSS`, go to HUNT with `s` = 0 and nothing captured.
- **LOCK, `s` ≠ 0, `fs` = 1 (early sync):**
  - Abandon the partial frame; no `valid` pulse and outputs hold.
  - Capture `d` into shadow 0, `s` = 1, clear the miss counter; `err_cnt` += 1.
- `en` = 0: all state, `s`, and outputs hold, and `valid` = 0.
- `err_cnt` saturates at 255 and never wraps. It is cleared only by reset.
- Miss counter width is 4 bits.

## Timing
- Latency: the slot-3 sample appears on `o3` one edge after it is presented; `o0`..`o2` update on that same edge.
- `valid` is registered and high for exactly one cycle per completed frame.
- Back-to-back frames at `en` = 1 continuously give a `valid` pulse every 4 cycles.
- `rst_n` falling mid-frame clears immediately, without waiting for a clock. The first sync after release is accepted on the first edge at which `rst_n` is high.
- No combinational path from any input to any output.

## Configuration
- `TDM_DEMUX_ERRCNT_EN` defined: the `err_cnt` port and its 8-bit saturating counter exist.
- Not defined: the port and counter are removed. Lock and flywheel behaviour is identical, and the miss counter is always present.

## Structure
- Shared package `tdm_pkg`:
  - state enum {HUNT, LOCK};
  - `TDM_SLOTS` = 4 and `TDM_SLOT_W` = 2;
  - `ERRCNT_W` = 8.
- One sub-module, `tdm_slot_ctr`:
  - 2-bit slot counter with `en`, synchronous load-to-1 (sync accept), clear, and wrap flag;
  - the top level holds the FSM, shadow and output registers, and the counters.

## Test plan
- **Reset mid-frame:** lock, feed 2 slots, pulse `rst_n` low → all outputs 0, `locked` = 0, `s` = 0 with no clock edge.
- **Clean lock, W = 4:** `en` = 1; `fs` with d = 0xA, then 0x5, 0x3, 0xC → on the 4th edge `o0..o3` = A, 5, 3, C, `valid` high one cycle, `locked` = 1.
- **Gapped strobe:** same frame with `en` low for 2 cycles between slots 1 and 2 → same outputs, `valid` delayed by 2 cycles, `s` held during the gap.
- **Flywheel and sync loss, `SYNC_LOSS` = 3:**
  - omit `fs` on the next 2 frames → both frames still produce `valid`, `locked` stays 1, `err_cnt` = 2;
  - a 3rd miss → `locked` = 0 and no further `valid` until `fs` is seen.
- **Early sync:** `fs` at `s` = 2 → no `valid`, outputs unchanged, `s` = 1 next, `err_cnt` += 1; the following 3 slots complete a frame normally.
- **Saturation (macro on):** force 300 early syncs → `err_cnt` = 255. Build without the macro → compiles, and lock behaviour is unchanged.
